// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected sources with per-source pending/lost flags, an enable
// mask and an IDLE -> GRANT -> SERVICE handshake. Define INTR_RR_EN for round-robin arbitration.
module intr_ctrl #(
  parameter int unsigned N_SRC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_req,
  input  logic                     mask_we,
  input  logic [N_SRC-1:0]         mask_wdata,
  input  logic                     ack,
  input  logic                     eoi,
  output logic                     irr,
  output logic [$clog2(N_SRC)-1:0] src_id,
  output logic [N_SRC-1:0]         pending,
  output logic [N_SRC-1:0]         lost,
  output logic                     busy
);

  localparam int unsigned IdW = $clog2(N_SRC);

  typedef enum logic [1:0] {StIdle, StGrant, StService} state_e;

  state_e           state_q;
  logic [N_SRC-1:0] src_req_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] lost_q;
  logic [IdW-1:0]   src_id_q;
  logic             irr_q;
  logic             busy_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] req_vec;
  logic [N_SRC-1:0] ack_clr;
  logic             ack_take;
  logic [IdW-1:0]   win_id;

  assign rise     = src_req & ~src_req_q;
  assign req_vec  = pending_q & mask_q;
  assign ack_take = (state_q == StGrant) && ack;

  always_comb begin
    ack_clr = '0;
    if (ack_take) ack_clr[src_id_q] = 1'b1;
  end

`ifdef INTR_RR_EN
  logic [IdW-1:0] last_grant_q;
  logic [IdW-1:0] rr_idx;
  logic           rr_found;

  // Search starts one past the last claimed source and wraps.
  always_comb begin
    win_id   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      rr_idx = IdW'((32'(last_grant_q) + 32'd1 + k) % N_SRC);
      if (!rr_found && req_vec[rr_idx]) begin
        rr_found = 1'b1;
        win_id   = rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IdW'(N_SRC - 1);
    end else if (ack_take) begin
      last_grant_q <= src_id_q;
    end
  end
`else
  // Descending scan so the lowest active index is the last assignment.
  always_comb begin
    win_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req_vec[IdW'(i)]) win_id = IdW'(i);
    end
  end
`endif

  always_ff @(posedge clk) begin
    // Sampling src_req during reset keeps a line held high from looking like a new event.
    src_req_q <= src_req;
    if (reset) begin
      state_q   <= StIdle;
      irr_q     <= 1'b0;
      busy_q    <= 1'b0;
      src_id_q  <= '0;
      pending_q <= '0;
      lost_q    <= '0;
      mask_q    <= '1;
    end else begin
      if (mask_we) mask_q <= mask_wdata;
      // A fresh edge on the claimed source re-arms it rather than counting as lost.
      pending_q <= (pending_q & ~ack_clr) | rise;
      lost_q    <= lost_q | (rise & pending_q & ~ack_clr);
      unique case (state_q)
        StIdle: begin
          if (|req_vec) begin
            src_id_q <= win_id;
            irr_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StGrant;
          end
        end
        StGrant: begin
          if (ack) begin
            irr_q   <= 1'b0;
            state_q <= StService;
          end else if (mask_we && !mask_wdata[src_id_q]) begin
            irr_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StService: begin
          if (eoi) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          irr_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign irr     = irr_q;
  assign src_id  = src_id_q;
  assign pending = pending_q;
  assign lost    = lost_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model.
module tb_intr_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned IdW = $clog2(N);

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   src_req;
  logic           mask_we;
  logic [N-1:0]   mask_wdata;
  logic           ack;
  logic           eoi;
  logic           irr;
  logic [IdW-1:0] src_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   lost;
  logic           busy;

  intr_ctrl #(.N_SRC(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_req    (src_req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eoi        (eoi),
    .irr        (irr),
    .src_id     (src_id),
    .pending    (pending),
    .lost       (lost),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: 0 = idle, 1 = granted, 2 = in service
  int          m_state;
  int unsigned m_id;
  int unsigned m_last;
  bit          m_irr;
  bit          m_busy;
  logic [N-1:0] m_pend, m_lost, m_mask, m_prev;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] rise, np, nl;
    bit claimed, found;
    int unsigned idx, win;
    if (reset) begin
      m_state = 0; m_irr = 0; m_busy = 0; m_id = 0;
      m_pend = '0; m_lost = '0; m_mask = '1; m_prev = src_req; m_last = N - 1;
      return;
    end
    rise = src_req & ~m_prev;
    m_prev = src_req;
    np = m_pend;
    nl = m_lost;
    for (int i = 0; i < N; i++) begin
      claimed = (m_state == 1) && ack && (i == m_id);
      if (rise[i]) begin
        if (m_pend[i] && !claimed) nl[i] = 1'b1;
        np[i] = 1'b1;
      end else if (claimed) begin
        np[i] = 1'b0;
      end
    end
    case (m_state)
      0: begin
        found = 0;
        win = 0;
        for (int unsigned k = 0; k < N; k++) begin
`ifdef INTR_RR_EN
          idx = (m_last + 1 + k) % N;
`else
          idx = k;
`endif
          if (!found && m_pend[idx] && m_mask[idx]) begin
            found = 1;
            win = idx;
          end
        end
        if (found) begin
          m_id = win; m_irr = 1; m_busy = 1; m_state = 1;
        end
      end
      1: begin
        if (ack) begin
          m_irr = 0; m_state = 2; m_last = m_id;
        end else if (mask_we && !mask_wdata[m_id]) begin
          m_irr = 0; m_busy = 0; m_state = 0;
        end
      end
      default: begin
        if (eoi) begin
          m_busy = 0; m_state = 0;
        end
      end
    endcase
    if (mask_we) m_mask = mask_wdata;
    m_pend = np;
    m_lost = nl;
  endtask

  task automatic check_model();
    cmp("irr", 32'(irr), 32'(m_irr));
    cmp("src_id", 32'(src_id), m_id);
    cmp("pending", 32'(pending), 32'(m_pend));
    cmp("lost", 32'(lost), 32'(m_lost));
    cmp("busy", 32'(busy), 32'(m_busy));
  endtask

  // Inputs are applied just after a rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) check_model();
    @(posedge clk);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  int unsigned first_id, second_id;

  initial begin
    reset = 1'b1; src_req = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
    tick(); tick();
    reset = 1'b0;
    cmp("rst_irr", 32'(irr), 32'd0);
    cmp("rst_pending", 32'(pending), 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_src_id", 32'(src_id), 32'd0);
    tick();

    // Single event on source 2: two-cycle latency, claim, end of interrupt
    src_req = 4'b0100; tick();
    cmp("single_pend", 32'(pending), 32'h4);
    cmp("single_irr_early", 32'(irr), 32'd0);
    src_req = '0; tick();
    cmp("single_irr", 32'(irr), 32'd1);
    cmp("single_id", 32'(src_id), 32'd2);
    tick(); tick();
    pulse_ack();
    cmp("single_ack_irr", 32'(irr), 32'd0);
    cmp("single_ack_pend", 32'(pending), 32'd0);
    cmp("single_ack_busy", 32'(busy), 32'd1);
    tick(); pulse_eoi();
    cmp("single_eoi_busy", 32'(busy), 32'd0);
    tick();

    // Simultaneous sources 1 and 3
`ifdef INTR_RR_EN
    first_id = 3; second_id = 1;
`else
    first_id = 1; second_id = 3;
`endif
    src_req = 4'b1010; tick();
    src_req = '0; tick();
    cmp("prio_first", 32'(src_id), first_id);
    cmp("prio_first_irr", 32'(irr), 32'd1);
    pulse_ack(); pulse_eoi(); tick();
    cmp("prio_second", 32'(src_id), second_id);
    cmp("prio_second_irr", 32'(irr), 32'd1);
    pulse_ack(); pulse_eoi(); tick();

    // Masked source stays pending until enabled
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(); mask_we = 1'b0;
    src_req = 4'b0001; tick(); src_req = '0; tick(); tick();
    cmp("mask_pend", 32'(pending), 32'h1);
    cmp("mask_irr_off", 32'(irr), 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
    cmp("mask_irr_still_off", 32'(irr), 32'd0);
    tick();
    cmp("mask_irr_on", 32'(irr), 32'd1);
    cmp("mask_id", 32'(src_id), 32'd0);
    pulse_ack(); pulse_eoi(); tick();

    // New edge coinciding with the claim re-arms the source without flagging loss
    src_req = 4'b0100; tick(); src_req = '0; tick();
    cmp("coin_irr", 32'(irr), 32'd1);
    src_req = 4'b0100; ack = 1'b1; tick(); ack = 1'b0; src_req = '0;
    cmp("coin_pend", 32'(pending), 32'h4);
    cmp("coin_lost", 32'(lost), 32'd0);
    cmp("coin_irr_off", 32'(irr), 32'd0);
    pulse_eoi(); tick();
    cmp("coin_regrant", 32'(irr), 32'd1);
    cmp("coin_regrant_id", 32'(src_id), 32'd2);

    // Second edge while still pending sets the sticky loss flag
    src_req = 4'b0100; tick(); src_req = '0; tick();
    cmp("lost_set", 32'(lost), 32'h4);
    pulse_ack(); pulse_eoi(); tick(); tick();
    cmp("lost_sticky", 32'(lost), 32'h4);

    // Reset while granted, line held high throughout
    src_req = 4'b0010; tick(); tick();
    cmp("rstg_irr_before", 32'(irr), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    cmp("rstg_irr", 32'(irr), 32'd0);
    cmp("rstg_pend", 32'(pending), 32'd0);
    cmp("rstg_lost", 32'(lost), 32'd0);
    tick(); tick(); tick();
    cmp("rstg_held_irr", 32'(irr), 32'd0);
    cmp("rstg_held_pend", 32'(pending), 32'd0);
    src_req = '0; tick(); src_req = 4'b0010; tick(); tick();
    cmp("rstg_new_irr", 32'(irr), 32'd1);
    cmp("rstg_new_id", 32'(src_id), 32'd1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) src_req[i] = ~src_req[i];
      end
      mask_we    = ($urandom_range(0, 11) == 0);
      mask_wdata = N'($urandom | $urandom);
      ack        = ($urandom_range(0, 2) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
